// File: rtl/pkg_line.sv
// Line-level shared definitions: associativity and replacement request opcodes.
package pkg_line;
    localparam int N_WAY = 16;
    localparam int WAY_W = $clog2(N_WAY);

    typedef enum logic [1:0] {
        HIT    = 2'd0,
        VICTIM = 2'd1,
        CLEAR  = 2'd2
    } repl_op_e;
endpackage

// File: rtl/pkg_plru.sv
// Tree-PLRU helpers: node 0 is the root, children of node k are 2k+1 and 2k+2.
package pkg_plru;
    import pkg_line::*;

    // Each visited node records the side that was just used.
    function automatic logic [N_WAY-2:0] plru_update(input logic [N_WAY-2:0] bits,
                                                     input logic [WAY_W-1:0] way);
        logic [N_WAY-2:0] r;
        logic [WAY_W-1:0] node;
        r    = bits;
        node = '0;
        for (int lvl = WAY_W - 1; lvl >= 0; lvl--) begin
            r[node] = way[lvl];
            node    = WAY_W'(2 * node + 1 + way[lvl]);
        end
        return r;
    endfunction

    // An invalid way always wins; otherwise walk away from the recorded side.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [N_WAY-2:0] bits,
                                                     input logic [N_WAY-1:0] vmask);
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] v;
        node = '0;
        v    = '0;
        if (&vmask) begin
            for (int lvl = WAY_W - 1; lvl >= 0; lvl--) begin
                v[lvl] = ~bits[node];
                node   = WAY_W'(2 * node + 1 + v[lvl]);
            end
        end else begin
            for (int i = N_WAY - 1; i >= 0; i--) begin
                if (!vmask[i]) v = WAY_W'(i);
            end
        end
        return v;
    endfunction
endpackage

// File: rtl/llc_plru_ram.sv
// PLRU state storage: one synchronous-read port and one write port, no reset.
module llc_plru_ram #(
    parameter  int N_SET = 1024,
    parameter  int W     = 15,
    localparam int SET_W = $clog2(N_SET)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [SET_W-1:0] i_waddr,
    input  logic [W-1:0]     i_wdata,
    input  logic [SET_W-1:0] i_raddr,
    output logic [W-1:0]     o_rdata
);
    logic [W-1:0] r_mem [N_SET];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/llc_repl_ctrl.sv
// LLC tree-PLRU replacement controller: one request in flight, INIT sweep clears
// the array after every reset. N_SET must be a power of two.
module llc_repl_ctrl
    import pkg_line::*;
    import pkg_plru::*;
#(
    parameter  int N_SET = 1024,
    localparam int SET_W = $clog2(N_SET)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  repl_op_e         req_op,
    input  logic [SET_W-1:0] req_set,
    input  logic [WAY_W-1:0] req_way,
    input  logic [N_WAY-1:0] req_vmask,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WAY_W-1:0] rsp_way
);
    typedef enum logic [1:0] {INIT, IDLE, READ, RESP} state_e;

    state_e           r_state;
    state_e           w_next;
    logic [SET_W-1:0] r_init_cnt;
    logic [SET_W-1:0] r_set;
    repl_op_e         r_op;
    logic [WAY_W-1:0] r_way;
    logic [N_WAY-1:0] r_vmask;
    logic [WAY_W-1:0] r_rsp_way;

    logic [N_WAY-2:0] w_rdata;
    logic [N_WAY-2:0] w_new_bits;
    logic [N_WAY-2:0] w_wdata;
    logic [WAY_W-1:0] w_sel_way;
    logic [SET_W-1:0] w_waddr;
    logic [SET_W-1:0] w_raddr;
    logic             w_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= INIT;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            INIT: if (r_init_cnt == SET_W'(N_SET - 1)) w_next = IDLE;
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = READ;
            end
            READ: w_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_init_cnt <= '0;
            r_rsp_way  <= '0;
        end else begin
            if (r_state == INIT) r_init_cnt <= r_init_cnt + 1'b1;
            if (r_state == READ) r_rsp_way  <= w_sel_way;
        end
    end

    // Request fields are datapath only; they are meaningful only after an accept.
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            r_op    <= req_op;
            r_set   <= req_set;
            r_way   <= req_way;
            r_vmask <= req_vmask;
        end
    end

    always_comb begin
        w_sel_way  = '0;
        w_new_bits = '0;
        case (r_op)
            HIT: begin
                w_sel_way  = r_way;
                w_new_bits = plru_update(w_rdata, r_way);
            end
            VICTIM: begin
                w_sel_way  = plru_victim(w_rdata, r_vmask);
                w_new_bits = plru_update(w_rdata, w_sel_way);
            end
            default: begin
                w_sel_way  = '0;
                w_new_bits = '0;
            end
        endcase
    end

    // Read address follows the live request in IDLE so data lands in READ.
    assign w_raddr = (r_state == IDLE) ? req_set : r_set;
    assign w_we    = (r_state == INIT) || (r_state == READ);
    assign w_waddr = (r_state == INIT) ? r_init_cnt : r_set;
    assign w_wdata = (r_state == INIT) ? '0 : w_new_bits;
    assign rsp_way = r_rsp_way;

    llc_plru_ram #(
        .N_SET (N_SET),
        .W     (N_WAY - 1)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );
endmodule

// File: tb/tb_llc_repl_ctrl.sv
// Scoreboard bench for llc_repl_ctrl with N_WAY=16, N_SET=1024.
module tb_llc_repl_ctrl;
    import pkg_line::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    repl_op_e    req_op;
    logic [9:0]  req_set;
    logic [3:0]  req_way;
    logic [15:0] req_vmask;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_way;

    int checks   = 0;
    int failures = 0;
    logic [3:0] sb[$];

    llc_repl_ctrl #(.N_SET(1024)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_set   (req_set),
        .req_way   (req_way),
        .req_vmask (req_vmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_way   (rsp_way)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one request to completion and reports what was observed.
    task automatic xact(input repl_op_e op, input logic [9:0] set, input logic [3:0] way,
                        input logic [15:0] vm, input int hold,
                        output logic [3:0] got, output int lat, output bit stable,
                        output bit idle_after, output bit to);
        int n;
        got = '0; lat = -1; stable = 1'b1; idle_after = 1'b0; to = 1'b0;
        n = 0;
        while (!req_ready && n < 2000) begin step(); n++; end
        if (!req_ready) begin to = 1'b1; return; end
        req_valid = 1'b1; req_op = op; req_set = set; req_way = way; req_vmask = vm;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin step(); lat++; end
        if (!rsp_valid) begin to = 1'b1; return; end
        got = rsp_way;
        for (int i = 0; i < hold; i++) begin
            step();
            if (rsp_valid !== 1'b1 || rsp_way !== got || req_ready !== 1'b0) stable = 1'b0;
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        idle_after = (req_ready === 1'b1) && (rsp_valid === 1'b0);
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = HIT; req_set = '0; req_way = '0; req_vmask = '0;
        step();
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_way !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b valid=%b way=%0d exp 0/0/0",
                     req_ready, rsp_valid, rsp_way);
        end
        rst_n = 1'b1;
        n = 0;
        while (!req_ready && n < 2000) begin step(); n++; end
        checks++;
        if (n != 1024) begin
            failures++;
            $display("FAIL init_cycles got=%0d exp=1024", n);
        end
    endtask

    task automatic test_victim_seq();
        logic [3:0] tab [5] = '{4'd15, 4'd7, 4'd11, 4'd3, 4'd13};
        logic [3:0] got, exp;
        int lat; bit st, ia, to;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(tab[i]);
            xact(VICTIM, 10'd0, 4'd0, 16'hFFFF, 0, got, lat, st, ia, to);
            exp = sb.pop_front();
            checks++;
            if (to || got !== exp) begin
                failures++;
                $display("FAIL victim_seq[%0d] got=%0d exp=%0d timeout=%0b", i, got, exp, to);
            end
        end
    endtask

    task automatic test_hit_victim();
        logic [3:0] got, exp;
        int lat; bit st, ia, to;
        sb.push_back(4'd15);
        xact(HIT, 10'd3, 4'd15, 16'h0000, 0, got, lat, st, ia, to);
        exp = sb.pop_front();
        checks++;
        if (to || got !== exp || lat != 2) begin
            failures++;
            $display("FAIL hit_echo got=%0d exp=%0d lat=%0d exp_lat=2", got, exp, lat);
        end
        sb.push_back(4'd7);
        xact(VICTIM, 10'd3, 4'd0, 16'hFFFF, 0, got, lat, st, ia, to);
        exp = sb.pop_front();
        checks++;
        if (to || got !== exp || lat != 2) begin
            failures++;
            $display("FAIL hit_then_victim got=%0d exp=%0d lat=%0d exp_lat=2", got, exp, lat);
        end
    endtask

    task automatic test_vmask();
        logic [15:0] vm [3]  = '{16'hFDFF, 16'h0000, 16'h7FFF};
        logic [3:0]  tab [3] = '{4'd9, 4'd0, 4'd15};
        logic [3:0] got, exp;
        int lat; bit st, ia, to;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(tab[i]);
            xact(VICTIM, 10'd8, 4'd0, vm[i], 0, got, lat, st, ia, to);
            exp = sb.pop_front();
            checks++;
            if (to || got !== exp) begin
                failures++;
                $display("FAIL vmask[%0d] vm=%h got=%0d exp=%0d", i, vm[i], got, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] got, exp;
        int lat; bit st, ia, to;
        sb.push_back(4'd6);
        xact(HIT, 10'd5, 4'd6, 16'h0000, 5, got, lat, st, ia, to);
        exp = sb.pop_front();
        checks++;
        if (to || got !== exp) begin
            failures++;
            $display("FAIL backpressure_way got=%0d exp=%0d", got, exp);
        end
        checks++;
        if (!st) begin
            failures++;
            $display("FAIL backpressure_hold got=unstable exp=stable");
        end
        checks++;
        if (!ia) begin
            failures++;
            $display("FAIL backpressure_idle got=%0b exp=1", ia);
        end
    endtask

    task automatic test_clear();
        logic [3:0] tab [3] = '{4'd15, 4'd0, 4'd15};
        repl_op_e   ops [3] = '{HIT, CLEAR, VICTIM};
        logic [3:0] got, exp;
        int lat; bit st, ia, to;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(tab[i]);
            xact(ops[i], 10'd2, 4'd15, 16'hFFFF, 0, got, lat, st, ia, to);
            exp = sb.pop_front();
            checks++;
            if (to || got !== exp) begin
                failures++;
                $display("FAIL clear[%0d] got=%0d exp=%0d", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_in_read();
        int n;
        logic [3:0] got, exp;
        int lat; bit st, ia, to;
        n = 0;
        while (!req_ready && n < 2000) begin step(); n++; end
        req_valid = 1'b1; req_op = HIT; req_set = 10'd4; req_way = 4'd15; req_vmask = '0;
        step();
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_way !== 4'd0) begin
            failures++;
            $display("FAIL read_reset_outputs got ready=%b valid=%b way=%0d exp 0/0/0",
                     req_ready, rsp_valid, rsp_way);
        end
        #1;
        rst_n = 1'b1;
        n = 0;
        while (!req_ready && n < 2000) begin
            step();
            n++;
            if (rsp_valid !== 1'b0) break;
        end
        checks++;
        if (n != 1024 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_reset_init got=%0d exp=1024 rsp_valid=%b", n, rsp_valid);
        end
        sb.push_back(4'd15);
        xact(VICTIM, 10'd4, 4'd0, 16'hFFFF, 0, got, lat, st, ia, to);
        exp = sb.pop_front();
        checks++;
        if (to || got !== exp) begin
            failures++;
            $display("FAIL read_reset_victim got=%0d exp=%0d", got, exp);
        end
    endtask

    initial begin
        test_reset();
        test_victim_seq();
        test_hit_victim();
        test_vmask();
        test_backpressure();
        test_clear();
        test_reset_in_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/llc_repl_ctrl.md
LLC_REPL_CTRL -- requirements
Module: llc_repl_ctrl

Interface
REQ-001 SHALL have parameter N_SET, default 1024, meaning number of LLC sets; must be a power of two.
REQ-002 SHALL take N_WAY from pkg_line (default 16); WAY_W = $clog2(N_WAY), SET_W = $clog2(N_SET).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-008 req_op  in  repl_op_e  HIT, VICTIM, or CLEAR.
REQ-009 req_set  in  SET_W  target set index.
REQ-010 req_way  in  WAY_W  accessed way; HIT only.
REQ-011 req_vmask  in  N_WAY  bit i = 1 when way i MESI != I; VICTIM only.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
REQ-014 rsp_way  out  WAY_W  HIT: echoed req_way; VICTIM: chosen way; CLEAR: 0.

Function
REQ-015 SHALL store N_WAY-1 tree-PLRU bits per set; node 0 = root, children of node k are 2k+1 and 2k+2.
REQ-016 Update for way w SHALL run MSB to LSB: bit[node] = w[level]; next node = 2*node + 1 + w[level]; all other bits are unchanged.
REQ-017 Victim SHALL be the lowest-index way with req_vmask bit 0; when req_vmask is all ones, victim bit = ~bit[node], traversing as in REQ-016.
REQ-018 HIT SHALL apply the REQ-016 update for req_way; VICTIM SHALL apply it for the chosen way; CLEAR SHALL write all bits of the set to 0.
REQ-019 FSM states SHALL be INIT, IDLE, READ, RESP.
REQ-020 INIT: write zero to sets 0..N_SET-1, one per cycle, taking N_SET cycles; req_ready = 0; then go to IDLE.
REQ-021 IDLE: req_ready = 1; on accept at cycle T, capture op/set/way/vmask and go to READ.
REQ-022 READ (T+1): synchronous array read completes; compute rsp_way and new bits; write back at end of cycle; go to RESP.
REQ-023 RESP: rsp_valid = 1 from T+2; rsp_way is stable until handshake; on handshake go to IDLE, so the earliest next accept is the following cycle.
REQ-024 req_ready SHALL be 0 in INIT, READ and RESP; one request outstanding, so no same-set hazard exists.
REQ-025 The PLRU write SHALL complete before rsp_valid rises; it is independent of when rsp_ready arrives.

Reset
REQ-026 On rst_n low, SHALL force state = INIT, init counter = 0, rsp_valid = 0, rsp_way = 0, req_ready = 0.
REQ-027 Reset during READ or RESP SHALL discard the request with no array write; the INIT sweep then restarts from set 0.
REQ-028 Array contents SHALL NOT be asynchronously reset; only the INIT sweep clears them.

Structure
REQ-029 repl_op_e {HIT, VICTIM, CLEAR}, WAY_W and N_WAY SHALL live in pkg_line; the tree update and victim helpers SHALL live in pkg_plru.
REQ-030 Storage SHALL be sub-module llc_plru_ram: N_SET x (N_WAY-1) bits, one synchronous-read port, one write port.

Verification (N_WAY=16, N_SET=1024)
REQ-031 Reset, wait 1024 cycles, then VICTIM set 0 with vmask 0xFFFF four times -> rsp_way sequence 15, 7, 11, 3.
REQ-032 HIT set 3 way 15, then VICTIM set 3 vmask 0xFFFF -> rsp_way 7; rsp_valid rises exactly 2 cycles after each accept.
REQ-033 VICTIM set 8 with vmask 0xFDFF -> 9; vmask 0x0000 -> 0; vmask 0x7FFF -> 15.
REQ-034 rsp_ready held low 5 cycles in RESP -> rsp_valid = 1, rsp_way constant, req_ready = 0 throughout; IDLE the cycle after release.
REQ-035 HIT set 2 way 15, CLEAR set 2, then VICTIM set 2 vmask 0xFFFF -> 15.
REQ-036 HIT set 4 way 15 with rst_n pulsed low in READ -> req_ready = 0 for 1024 cycles, then VICTIM set 4 vmask 0xFFFF -> 15.
